// File: rtl/io_bus_responder.sv
// io_bus_responder: peripheral end of the CPU IO bus (LED, seven-segment, hex entry).
// Latency: register writes and entry/commit pulses are visible one cycle later; io_din is combinational.
// Backpressure: out_vld/out_ack toward the display; the CPU polls in_vld; a commit while in_vld is set is dropped and flagged in ovf.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   io_addr/io_dout/io_we/io_rd/io_din   CPU IO bus (word aligned, io_addr[1:0] ignored)
//   digit_p/digit/del_p/ent_p            hex entry pulses from switches/buttons
//   out_ack                              display consumed seg_data
//   led_out, seg_data, out_vld           display-side registers
//   entry_buf, in_vld, ovf               live entry, committed-input flag, sticky drop flag
// Optional macro IOBUS_ERR_EN: adds sticky bus_err for unmapped accesses (bit 2 at 0x14).
module io_bus_responder #(
  parameter int ADDR_W = 8,
  parameter int LED_W  = 16,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_W-1:0]     io_addr,
  input  logic [31:0]           io_dout,
  input  logic                  io_we,
  input  logic                  io_rd,
  output logic [31:0]           io_din,
  input  logic                  digit_p,
  input  logic [3:0]            digit,
  input  logic                  del_p,
  input  logic                  ent_p,
  input  logic                  out_ack,
  output logic [LED_W-1:0]      led_out,
  output logic [31:0]           seg_data,
  output logic                  out_vld,
  output logic [4*DIGITS-1:0]   entry_buf,
  output logic                  in_vld,
  output logic                  ovf
`ifdef IOBUS_ERR_EN
  ,
  output logic                  bus_err
`endif
);

  localparam int EW     = 4 * DIGITS;
  localparam int WIDX_W = ADDR_W - 2;

  // Word indices of the register map.
  localparam logic [WIDX_W-1:0] W_LED  = WIDX_W'(0);  // 0x00
  localparam logic [WIDX_W-1:0] W_STAT = WIDX_W'(1);  // 0x04
  localparam logic [WIDX_W-1:0] W_SEG  = WIDX_W'(2);  // 0x08
  localparam logic [WIDX_W-1:0] W_INV  = WIDX_W'(3);  // 0x0C
  localparam logic [WIDX_W-1:0] W_IND  = WIDX_W'(4);  // 0x10
  localparam logic [WIDX_W-1:0] W_CTL  = WIDX_W'(5);  // 0x14

  logic [WIDX_W-1:0] widx;
  assign widx = io_addr[ADDR_W-1:2];

  logic [LED_W-1:0] led_q,     led_d;
  logic [31:0]      seg_q,     seg_d;
  logic             out_vld_q, out_vld_d;
  logic [EW-1:0]    entry_q,   entry_d;
  logic [31:0]      in_data_q, in_data_d;
  logic             in_vld_q,  in_vld_d;
  logic             ovf_q,     ovf_d;
  logic             rd_clr;

`ifdef IOBUS_ERR_EN
  logic berr_q, berr_d;
  logic unmapped;
  assign unmapped = (widx > W_CTL);
`endif

  // A read of in_data this cycle frees the slot, so a same-cycle commit is accepted.
  assign rd_clr = io_rd && (widx == W_IND);

  always_comb begin
    led_d     = led_q;
    seg_d     = seg_q;
    out_vld_d = out_vld_q;
    entry_d   = entry_q;
    in_data_d = in_data_q;
    in_vld_d  = in_vld_q;
    ovf_d     = ovf_q;
`ifdef IOBUS_ERR_EN
    berr_d    = berr_q;
`endif

    if (io_we && (widx == W_LED)) begin
      led_d = io_dout[LED_W-1:0];
    end

    // Ack clears first so that a same-cycle seg write leaves out_vld set.
    if (out_ack) begin
      out_vld_d = 1'b0;
    end
    if (io_we && (widx == W_SEG)) begin
      seg_d     = io_dout;
      out_vld_d = 1'b1;
    end

    if (io_we && (widx == W_CTL) && io_dout[1]) begin
      ovf_d = 1'b0;
    end

    if (rd_clr) begin
      in_vld_d = 1'b0;
    end

    // Only the highest-priority entry pulse acts: ent_p > del_p > digit_p.
    if (ent_p) begin
      if (!in_vld_q || rd_clr) begin
        in_data_d = 32'(entry_q);
        in_vld_d  = 1'b1;
        entry_d   = '0;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (del_p) begin
      entry_d = entry_q >> 4;
    end else if (digit_p) begin
      entry_d = {entry_q[EW-5:0], digit};
    end

`ifdef IOBUS_ERR_EN
    if (io_we && (widx == W_CTL) && io_dout[2]) begin
      berr_d = 1'b0;
    end
    if ((io_we || io_rd) && unmapped) begin
      berr_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      led_q     <= '0;
      seg_q     <= '0;
      out_vld_q <= 1'b0;
      entry_q   <= '0;
      in_data_q <= '0;
      in_vld_q  <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef IOBUS_ERR_EN
      berr_q    <= 1'b0;
`endif
    end else begin
      led_q     <= led_d;
      seg_q     <= seg_d;
      out_vld_q <= out_vld_d;
      entry_q   <= entry_d;
      in_data_q <= in_data_d;
      in_vld_q  <= in_vld_d;
      ovf_q     <= ovf_d;
`ifdef IOBUS_ERR_EN
      berr_q    <= berr_d;
`endif
    end
  end

  always_comb begin
    io_din = '0;
    if (io_rd) begin
      case (widx)
        W_STAT:  io_din = {31'b0, ~out_vld_q};
        W_INV:   io_din = {31'b0, in_vld_q};
        W_IND:   io_din = in_data_q;
`ifdef IOBUS_ERR_EN
        W_CTL:   io_din = {29'b0, berr_q, ovf_q, in_vld_q};
`else
        W_CTL:   io_din = {30'b0, ovf_q, in_vld_q};
`endif
        default: io_din = '0;
      endcase
    end
  end

  assign led_out   = led_q;
  assign seg_data  = seg_q;
  assign out_vld   = out_vld_q;
  assign entry_buf = entry_q;
  assign in_vld    = in_vld_q;
  assign ovf       = ovf_q;
`ifdef IOBUS_ERR_EN
  assign bus_err   = berr_q;
`endif

endmodule

// File: tb/tb_io_bus_responder.sv
module tb_io_bus_responder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  io_addr = '0;
  logic [31:0] io_dout = '0;
  logic        io_we = 1'b0;
  logic        io_rd = 1'b0;
  logic [31:0] io_din;
  logic        digit_p = 1'b0;
  logic [3:0]  digit = '0;
  logic        del_p = 1'b0;
  logic        ent_p = 1'b0;
  logic        out_ack = 1'b0;
  logic [15:0] led_out;
  logic [31:0] seg_data;
  logic        out_vld;
  logic [31:0] entry_buf;
  logic        in_vld;
  logic        ovf;
`ifdef IOBUS_ERR_EN
  logic        bus_err;
`endif

  io_bus_responder #(.ADDR_W(8), .LED_W(16), .DIGITS(8)) dut (
    .clk(clk), .rstn(rstn), .io_addr(io_addr), .io_dout(io_dout),
    .io_we(io_we), .io_rd(io_rd), .io_din(io_din),
    .digit_p(digit_p), .digit(digit), .del_p(del_p), .ent_p(ent_p),
    .out_ack(out_ack), .led_out(led_out), .seg_data(seg_data),
    .out_vld(out_vld), .entry_buf(entry_buf), .in_vld(in_vld), .ovf(ovf)
`ifdef IOBUS_ERR_EN
    , .bus_err(bus_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rd;
    logic [31:0] din;
    logic [31:0] led, seg, entry;
    logic        outv, inv, ovf, berr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: plain integers and flags.
  longint m_led = 0, m_seg = 0, m_entry = 0, m_indata = 0;
  bit     m_outv = 0, m_inv = 0, m_ovf = 0, m_berr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint model_read(input int a);
    case (a)
      'h04: return m_outv ? 0 : 1;
      'h0C: return m_inv;
      'h10: return m_indata;
`ifdef IOBUS_ERR_EN
      'h14: return m_berr * 4 + m_ovf * 2 + m_inv;
`else
      'h14: return m_ovf * 2 + m_inv;
`endif
      default: return 0;
    endcase
  endfunction

  // One bus cycle: drive after the edge, record what the DUT should show this cycle,
  // then advance the model to the state after the next edge.
  task automatic cyc(input bit r, input logic [7:0] a, input logic [31:0] d,
                     input bit we, input bit rd, input bit dp, input logic [3:0] dg,
                     input bit del, input bit ent, input bit ack);
    exp_t e;
    int   wa;
    bit   rdclr;
    bit   n_outv, n_inv, n_ovf, n_berr;
    longint n_entry, n_indata;
    @(posedge clk);
    #1;
    rstn = r; io_addr = a; io_dout = d; io_we = we; io_rd = rd;
    digit_p = dp; digit = dg; del_p = del; ent_p = ent; out_ack = ack;
    wa = int'(a) & 'hFC;

    e.rd    = rd;
    e.din   = rd ? 32'(model_read(wa)) : 32'h0;
    e.led   = 32'(m_led);
    e.seg   = 32'(m_seg);
    e.entry = 32'(m_entry);
    e.outv  = m_outv;
    e.inv   = m_inv;
    e.ovf   = m_ovf;
    e.berr  = m_berr;
    exp_q.push_back(e);

    if (!r) begin
      m_led = 0; m_seg = 0; m_entry = 0; m_indata = 0;
      m_outv = 0; m_inv = 0; m_ovf = 0; m_berr = 0;
    end else begin
      n_outv = ack ? 1'b0 : m_outv;
      n_ovf = m_ovf;
      n_berr = m_berr;
      n_entry = m_entry;
      n_indata = m_indata;
      if (we && wa == 'h00) m_led = d & 'hFFFF;
      if (we && wa == 'h08) begin m_seg = d; n_outv = 1; end
      if (we && wa == 'h14 && d[1]) n_ovf = 0;
      if (we && wa == 'h14 && d[2]) n_berr = 0;
      if ((we || rd) && wa > 'h14) n_berr = 1;
      rdclr = rd && wa == 'h10;
      n_inv = rdclr ? 1'b0 : m_inv;
      if (ent) begin
        if (!m_inv || rdclr) begin
          n_indata = m_entry; n_inv = 1; n_entry = 0;
        end else begin
          n_ovf = 1;
        end
      end else if (del) begin
        n_entry = m_entry / 16;
      end else if (dp) begin
        n_entry = (m_entry * 16 + dg) % 64'h1_0000_0000;
      end
      m_outv = n_outv; m_inv = n_inv; m_ovf = n_ovf; m_berr = n_berr;
      m_entry = n_entry; m_indata = n_indata;
    end
  endtask

  task automatic idle();                                   cyc(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d); cyc(1, a, d, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic rd(input logic [7:0] a);                   cyc(1, a, 0, 0, 1, 0, 0, 0, 0, 0); endtask
  task automatic dig(input logic [3:0] v);                  cyc(1, 8'h00, 0, 0, 0, 1, v, 0, 0, 0); endtask

  // Monitor: every negedge the DUT presents its registered state and io_din.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.rd) chk("io_din", io_din, e.din);
        else      chk("io_din_idle", io_din, 32'h0);
        chk("led_out",   32'(led_out), e.led);
        chk("seg_data",  seg_data, e.seg);
        chk("entry_buf", entry_buf, e.entry);
        chk("out_vld",   32'(out_vld), 32'(e.outv));
        chk("in_vld",    32'(in_vld), 32'(e.inv));
        chk("ovf",       32'(ovf), 32'(e.ovf));
`ifdef IOBUS_ERR_EN
        chk("bus_err",   32'(bus_err), 32'(e.berr));
`endif
      end
    end
  end

  initial begin
    logic [7:0] addrs [8];
    logic [7:0] a;
    addrs[0] = 8'h00; addrs[1] = 8'h04; addrs[2] = 8'h08; addrs[3] = 8'h0C;
    addrs[4] = 8'h10; addrs[5] = 8'h14; addrs[6] = 8'h3C; addrs[7] = 8'h18;

    cyc(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    wr(8'h00, 32'h0000A5A5);
    idle();
    wr(8'h08, 32'h12345678);
    rd(8'h04);
    cyc(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1);
    rd(8'h04);
    cyc(1, 8'h08, 32'hCAFEF00D, 1, 0, 0, 0, 0, 0, 1);  // seg write beats ack
    rd(8'h05);                                          // low address bits ignored
    dig(4'h1); dig(4'h2); dig(4'h3);
    cyc(1, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    rd(8'h0C);
    rd(8'h10);
    rd(8'h0C);
    cyc(1, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0);              // delete from empty
    for (int i = 1; i <= 9; i++) dig(4'(i));
    cyc(1, 8'h00, 0, 0, 0, 1, 4'hF, 1, 1, 0);           // ent wins over del/digit
    dig(4'h5);
    cyc(1, 8'h00, 0, 0, 0, 1, 4'h7, 1, 0, 0);           // del wins over digit
    dig(4'h6);
    cyc(1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);              // dropped: ovf
    rd(8'h14);
    cyc(1, 8'h10, 0, 0, 1, 0, 0, 0, 1, 0);              // read + commit same cycle
    rd(8'h10);
    wr(8'h14, 32'h2);
    rd(8'h14);
    wr(8'h0C, 32'hFFFFFFFF);                            // read-only, ignored
    dig(4'hA); dig(4'hB);
    cyc(1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    dig(4'hA); dig(4'hB);
    cyc(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);              // reset mid-entry
    idle();
    rd(8'h3C);
    rd(8'h14);
    wr(8'h14, 32'h4);
    rd(8'h14);

    for (int i = 0; i < 2000; i++) begin
      a = addrs[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) a = 8'($urandom);
      else a = a | 8'($urandom_range(0, 3));
      cyc(($urandom_range(0, 149) != 0), a, $urandom,
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 2) == 0), 4'($urandom), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 6) == 0), ($urandom_range(0, 4) == 0));
    end
    idle();

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d expected=0 pending entries", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
